// File: rtl/panel_debounce_pkg.sv
// Shared parameters, channel indices and payload types for the PDP-8/e front-panel debouncer.
package panel_debounce_pkg;

    localparam int unsigned TICK_DIV_DEF     = 50000;
    localparam int unsigned STABLE_TICKS_DEF = 8;

    localparam int unsigned N_KEYS = 6;
    localparam int unsigned N_TOG  = 2;
    localparam int unsigned N_SR   = 12;
    localparam int unsigned N_CHAN = N_KEYS + N_TOG + N_SR;

    // Key bit positions, matching raw_keys_n / keys
    localparam int unsigned K_CLEAR     = 5;
    localparam int unsigned K_EXTD_ADDR = 4;
    localparam int unsigned K_ADDR_LOAD = 3;
    localparam int unsigned K_DEP       = 2;
    localparam int unsigned K_EXAM      = 1;
    localparam int unsigned K_CONT      = 0;

    localparam int unsigned T_SS   = 1;
    localparam int unsigned T_HALT = 0;

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_bits(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DBNCE_NU_BITS = cnt_bits(STABLE_TICKS_DEF);
    localparam int unsigned PRESCALE_BITS = cnt_bits(TICK_DIV_DEF);

    typedef enum logic {
        CH_STABLE  = 1'b0,
        CH_PENDING = 1'b1
    } chan_state_t;

    typedef struct packed {
        logic [N_KEYS-1:0] keys;
        logic [N_TOG-1:0]  tog;
        logic [N_SR-1:0]   sr;
    } panel_bits_t;

endpackage

// File: rtl/debounce_chan.sv
// One front-panel channel: two-flop synchroniser, active-low to active-high inversion,
// and a tick-sampled stability counter that flips the debounced level.
module debounce_chan
    import panel_debounce_pkg::*;
#(
    parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw_n,
    output logic lvl
);

    localparam int unsigned     SCNT_W   = cnt_bits(STABLE_TICKS);
    localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STABLE_TICKS - 1);

    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    logic              lvl_q, lvl_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic              smp_c;
    chan_state_t       state_c;

    assign smp_c   = ~s2_q;
    assign state_c = (scnt_q == '0) ? CH_STABLE : CH_PENDING;
    assign lvl     = lvl_q;

    // Synchroniser flops idle at 1, the released raw level
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            lvl_q  <= 1'b0;
            scnt_q <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            lvl_q  <= lvl_d;
            scnt_q <= scnt_d;
        end
    end

    always_comb begin
        s1_d   = raw_n;
        s2_d   = s1_q;
        lvl_d  = lvl_q;
        scnt_d = scnt_q;
        if (tick) begin
            unique case (state_c)
                CH_STABLE: begin
                    if (smp_c != lvl_q) begin
                        scnt_d = SCNT_W'(1);
                    end
                end
                CH_PENDING: begin
                    // One agreeing sample cancels the pending flip
                    if (smp_c == lvl_q) begin
                        scnt_d = '0;
                    end else if (scnt_q == SCNT_MAX) begin
                        lvl_d  = smp_c;
                        scnt_d = '0;
                    end else begin
                        scnt_d = scnt_q + SCNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/panel_debounce.sv
// Front-panel switch conditioner: shared sample-tick prescaler, 20 debounce channels,
// key rising-edge pulses and key_any for the trigger sequencer.
module panel_debounce
    import panel_debounce_pkg::*;
#(
    parameter int unsigned TICK_DIV     = TICK_DIV_DEF,
    parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] raw_keys_n,
    input  logic [N_TOG-1:0]  raw_tog_n,
    input  logic [N_SR-1:0]   raw_sr_n,
    output logic [N_KEYS-1:0] keys,
    output logic [N_TOG-1:0]  tog,
    output logic [N_SR-1:0]   sr,
    output logic [N_KEYS-1:0] key_edge,
    output logic              key_any
);

    localparam int unsigned       PCNT_W   = cnt_bits(TICK_DIV);
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(TICK_DIV - 1);

    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic [N_KEYS-1:0] keys_dly_q, keys_dly_d;
    logic              tick_c;
    panel_bits_t       raw_n_c;
    panel_bits_t       lvl_c;

    assign raw_n_c = {raw_keys_n, raw_tog_n, raw_sr_n};
    assign tick_c  = (pcnt_q == PCNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt_q     <= '0;
            keys_dly_q <= '0;
        end else begin
            pcnt_q     <= pcnt_d;
            keys_dly_q <= keys_dly_d;
        end
    end

    // Prescaler wraps on its terminal count rather than overflowing
    always_comb begin
        pcnt_d     = pcnt_q;
        keys_dly_d = lvl_c.keys;
        if (tick_c) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + PCNT_W'(1);
        end
    end

    for (genvar i = 0; i < N_CHAN; i++) begin : g_chan
        debounce_chan #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .tick  (tick_c),
            .raw_n (raw_n_c[i]),
            .lvl   (lvl_c[i])
        );
    end

    assign keys     = lvl_c.keys;
    assign tog      = lvl_c.tog;
    assign sr       = lvl_c.sr;
    assign key_edge = lvl_c.keys & ~keys_dly_q;
    assign key_any  = |lvl_c.keys;

endmodule

// File: tb/tb_panel_debounce.sv
// Scoreboard bench for panel_debounce with TICK_DIV=4, STABLE_TICKS=3.
module tb_panel_debounce;
    import panel_debounce_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  raw_keys_n = '1;
    logic [1:0]  raw_tog_n  = '1;
    logic [11:0] raw_sr_n   = '1;
    logic [5:0]  keys;
    logic [1:0]  tog;
    logic [11:0] sr;
    logic [5:0]  key_edge;
    logic        key_any;

    panel_debounce #(
        .TICK_DIV    (4),
        .STABLE_TICKS(3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .raw_keys_n(raw_keys_n),
        .raw_tog_n (raw_tog_n),
        .raw_sr_n  (raw_sr_n),
        .keys      (keys),
        .tog       (tog),
        .sr        (sr),
        .key_edge  (key_edge),
        .key_any   (key_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [26:0] val;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          drain_req = 0;
    int          drain_seen = 0;
    logic [26:0] prev_obs = '0;

    localparam logic [5:0]  DEP_M = 6'b000100;
    localparam logic [11:0] SR_V  = 12'o2525;

    function automatic logic [26:0] mk(input logic [5:0] k, input logic [1:0] t,
                                       input logic [11:0] s, input logic [5:0] e);
        return {k, t, s, e, |k};
    endfunction

    // Cycle 0 is the first cycle with reset low
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Monitor: an output change (or a scheduled check cycle) pops the next expectation
    always @(negedge clk) begin
        logic [26:0] obs;
        exp_t        e;
        obs = {keys, tog, sr, key_edge, key_any};
        if (!reset) begin
            if (sb.size() > 0 && (obs != prev_obs || sb[0].cyc == cyc)) begin
                e = sb.pop_front();
                n_total++;
                if (e.cyc == cyc && e.val == obs) n_pass++;
                else $display("FAIL %s: at cyc %0d got %h, required %h at cyc %0d",
                              e.name, cyc, obs, e.val, e.cyc);
            end else if (obs != prev_obs) begin
                n_total++;
                $display("FAIL spurious_change: at cyc %0d got %h, required %h (no change)",
                         cyc, obs, prev_obs);
            end
        end
        if (drain_req != drain_seen) begin
            n_total++;
            if (sb.size() == 0) begin
                n_pass++;
            end else begin
                $display("FAIL drain: %0d events pending, first %s required at cyc %0d, got none",
                         sb.size(), sb[0].name, sb[0].cyc);
                sb.delete();
            end
            drain_seen = drain_req;
        end
        prev_obs = obs;
    end

    task automatic expect_at(input int c, input logic [26:0] v, input string nm);
        sb.push_back('{c, v, nm});
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        raw_keys_n = '1;
        raw_tog_n  = '1;
        raw_sr_n   = '1;
        reset      = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        expect_at(0, '0, "reset_state");
    endtask

    task automatic drain();
        drain_req++;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Press dep from cycle 0, release at cycle 20
        do_reset();
        raw_keys_n[K_DEP] = 1'b0;
        expect_at(12, mk(DEP_M, 2'b00, '0, DEP_M), "dep_press");
        expect_at(13, mk(DEP_M, 2'b00, '0, '0), "dep_edge_end");
        goto(20);
        raw_keys_n[K_DEP] = 1'b1;
        expect_at(32, '0, "dep_release");
        goto(40);
        drain();

        // Glitch during cycles 0-5 must be rejected; re-press at 10 needs full debounce
        do_reset();
        raw_keys_n[K_DEP] = 1'b0;
        goto(6);
        raw_keys_n[K_DEP] = 1'b1;
        goto(10);
        raw_keys_n[K_DEP] = 1'b0;
        expect_at(24, mk(DEP_M, 2'b00, '0, DEP_M), "repress_after_glitch");
        expect_at(25, mk(DEP_M, 2'b00, '0, '0), "repress_edge_end");
        goto(32);
        drain();

        // Switch register: all 12 bits flip together
        do_reset();
        raw_sr_n = 12'o5252;
        expect_at(12, mk('0, 2'b00, SR_V, '0), "sr_pattern");
        goto(20);
        drain();

        // Chatter on halt, then held closed from cycle 39
        do_reset();
        for (int c = 0; c < 40; c++) begin
            goto(c);
            raw_tog_n[T_HALT] = ((c / 3) % 2 == 0);
        end
        goto(40);
        raw_tog_n[T_HALT] = 1'b0;
        expect_at(52, mk('0, 2'b01, '0, '0), "halt_after_chatter");
        goto(60);
        drain();

        // Reset during a pending dep press restarts the debounce
        do_reset();
        raw_sr_n = 12'o5252;
        expect_at(12, mk('0, 2'b00, SR_V, '0), "sr_before_reset");
        goto(16);
        raw_keys_n[K_DEP] = 1'b0;
        goto(25);
        expect_at(0, '0, "reset_mid_pending");
        expect_at(12, mk(DEP_M, 2'b00, SR_V, DEP_M), "dep_after_reset");
        expect_at(13, mk(DEP_M, 2'b00, SR_V, '0), "dep_after_reset_edge_end");
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        goto(20);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/panel_debounce.md
# panel_debounce

Synchronises and debounces every raw front-panel switch of the PDP-8/e console: six momentary keys, two toggles and the 12-bit switch register. It is the stage directly upstream of the front-panel trigger sequencer. Its debounced key levels drive that sequencer's `clear`, `extd_addr`, `addr_load`, `dep`, `exam` and `cont` inputs, and its toggle levels drive `sing_step` and `halt`. All raw inputs are active-low (switch closes to ground, pulled up). All outputs are active-high, debounced, and glitch-free.

## Interface
Parameters:
- `TICK_DIV`, default 50000: clk cycles per sample tick (1 ms at 50 MHz).
- `STABLE_TICKS`, default 8: consecutive differing samples required to flip a channel; legal range 2..255.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high; clock clk.
- `raw_keys_n` in 6: {clear, extd_addr, addr_load, dep, exam, cont}, bit 5 = clear; active-low.
- `raw_tog_n` in 2: {sing_step, halt}, bit 1 = sing_step; active-low.
- `raw_sr_n` in 12: switch register, bit 11 = SR0 (MSB); active-low.
- `keys` out 6: debounced key levels, same order as `raw_keys_n`.
- `tog` out 2: debounced toggle levels.
- `sr` out 12: debounced switch register.
- `key_edge` out 6: one-cycle pulse on each debounced key rising edge.
- `key_any` out 1: OR of `keys`.

## Operation
- Synchroniser: each of the 20 raw bits goes through 2 flops (`s1`, `s2`) and is inverted after `s2`, giving the synchronised sample `smp`. The flops reset to 1, which is the idle raw level.
- Prescaler: counter `pcnt` runs 0..TICK_DIV-1 and wraps. `tick` = (`pcnt` == TICK_DIV-1). `pcnt` resets to 0.
- Per-channel state is the debounced level `lvl` and a stability counter `scnt` of width clog2(STABLE_TICKS). Update rules:
  - Non-tick cycle: hold.
  - Tick with `smp` == `lvl`: `scnt` := 0.
  - Tick with `smp` != `lvl` and `scnt` < STABLE_TICKS-1: increment `scnt`.
  - Tick with `smp` != `lvl` and `scnt` == STABLE_TICKS-1: `lvl` := `smp` and `scnt` := 0.
- Two states per channel, STABLE (`scnt` = 0) and PENDING (`scnt` > 0). A single agreeing sample returns the channel to STABLE. Glitches shorter than STABLE_TICKS samples are therefore rejected.
- `key_edge[i]` = `lvl[i]` & ~`lvl_d[i]`, where `lvl_d` is `lvl` registered one cycle. It is registered-free combinational from flops, high exactly 1 cycle.
- `key_any` is combinational OR of `keys`.
- All channels share the same tick. Simultaneous changes on several channels flip in the same cycle.

## Timing
- Reset values: `keys` = 0, `tog` = 0, `sr` = 0, `key_edge` = 0, `key_any` = 0, every `scnt` = 0, `pcnt` = 0, `lvl_d` = 0.
- A switch held closed through reset release is reported only after a full debounce. There is no bypass at power-up.
- Latency from a raw change that stays stable:
  - 2 cycles of synchroniser delay.
  - Plus a wait of 0..TICK_DIV-1 cycles to the next tick.
  - Plus (STABLE_TICKS-1)·TICK_DIV cycles.
  - Plus 1 cycle (output registered on the flipping tick).
- Reset mid-PENDING aborts the count. Outputs return to 0 on the cycle after reset is sampled.
- `scnt` and `pcnt` never overflow: both compare against their terminal values before incrementing.
- Release is symmetric with press and uses the same rules.

## Structure
- Shared package (the team's parameters file) holds:
  - `TICK_DIV` and `STABLE_TICKS` defaults, with `dbnce_nu_bits` derived from them.
  - Channel-index constants: K_CLEAR=5 … K_CONT=0, T_SS=1, T_HALT=0.
- One sub-module, `debounce_chan`, holds the synchroniser, `lvl` and `scnt` for one bit, with the tick as an input. It is instantiated 20 times in a generate loop.
- The prescaler, the edge detectors and `key_any` live in the top level.

## Test plan
All scenarios use TICK_DIV=4 and STABLE_TICKS=3. Ticks fall at cycles 3, 7, 11, … after reset deassert. Cycle 0 is the first cycle with reset low.
- `raw_keys_n[dep]` driven 0 from cycle 0 -> `keys[dep]` and `key_any` go 1 at cycle 12. `key_edge[dep]` is 1 at cycle 12 only. All other outputs stay 0.
- `raw_keys_n[dep]` low during cycles 0–5 only -> `keys[dep]` never asserts, and `scnt` is back at 0 after the tick at cycle 11.
- `raw_sr_n` = 12'o5252 (active-low, i.e. sr = 12'o2525) applied at cycle 0 -> `sr` = 12'o2525 at cycle 12, with all 12 bits changing in the same cycle.
- `dep` pressed and then released at cycle 20 -> `keys[dep]` falls at cycle 32 (ticks 23, 27, 31). No `key_edge` pulse on release.
- Chatter: `raw_tog_n[halt]` toggles every 3 cycles for 40 cycles, then is held low -> `tog[halt]` stays 0 during the chatter and rises exactly 3 ticks after the last transition plus 1 cycle.
- Reset asserted at cycle 9 during a pending `dep` press -> all outputs are 0 at cycle 10. After release, the full 3-tick debounce is required again.
